draw_cmd_queue: RTL

- Command buffer and sequencer that sits directly upstream of the rectangle draw stage.
- Game logic pushes rectangle commands (origin, size, colour). This block queues them in a FIFO and replays them one at a time into the draw stage.
- It runs the draw stage's draw/update/draw_done protocol, so game logic never waits on pixel-level timing.

---
 rtl/draw_cmd_if.sv | 26 ++
 rtl/draw_cmd_queue.sv | 67 ++++++
 2 files changed

// File: rtl/draw_cmd_if.sv
// draw_cmd_if: command push handshake plus the draw-stage drive and completion bundle
interface draw_cmd_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_x;
  logic [6:0] cmd_y;
  logic [4:0] cmd_w;
  logic [4:0] cmd_h;
  logic [2:0] cmd_c;
  logic       draw;
  logic       update;
  logic [7:0] x_in;
  logic [6:0] y_in;
  logic [4:0] width;
  logic [4:0] height;
  logic [2:0] c_in;
  logic       draw_done;
  modport master (
    output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_c, draw_done,
    input  cmd_ready, draw, update, x_in, y_in, width, height, c_in
  );
  modport slave (
    input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_c, draw_done,
    output cmd_ready, draw, update, x_in, y_in, width, height, c_in
  );
endinterface

// File: rtl/draw_cmd_queue.sv
// draw_cmd_queue: FIFO of rectangle commands replayed one at a time into the draw stage
module draw_cmd_queue #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic         clk,
  input  logic         reset,
  draw_cmd_if.slave    bus,
  input  logic         abort,
  output logic [AW:0]  count,
  output logic         busy,
  output logic         idle,
  output logic         dropped
);
  typedef enum logic [2:0] {IDLE, LOAD, UPDATE, DRAW, RELEASE} state_t;
  state_t state, state_next;
  logic [27:0]   mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          push, pop, zero;
  assign bus.cmd_ready = count != (AW+1)'(DEPTH);
  assign push = bus.cmd_valid && bus.cmd_ready && !abort;
  assign pop  = state == IDLE && count != '0 && !abort;
  assign zero = bus.width == '0 || bus.height == '0;
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_next;
  // abort on an empty idle queue has nothing to cancel, so it must not leave IDLE
  always_comb begin
    state_next = state;
    if (abort) state_next = (state == IDLE && count == '0) ? IDLE : RELEASE;
    else
      case (state)
        IDLE:    state_next = pop ? LOAD : IDLE;
        LOAD:    state_next = zero ? IDLE : UPDATE;
        UPDATE:  state_next = DRAW;
        DRAW:    state_next = bus.draw_done ? RELEASE : DRAW;
        default: state_next = IDLE;
      endcase
  end
  always_comb begin
    bus.draw   = state == UPDATE || state == DRAW;
    bus.update = state == UPDATE;
    busy       = state != IDLE;
    idle       = count == '0 && state == IDLE;
    dropped    = state == LOAD && zero;
  end
  always_ff @(posedge clk)
    if (push) mem[wptr] <= {bus.cmd_x, bus.cmd_y, bus.cmd_w, bus.cmd_h, bus.cmd_c};
  always_ff @(posedge clk)
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      {bus.x_in, bus.y_in, bus.width, bus.height, bus.c_in} <= '0;
    end else if (abort) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop) begin
        rptr <= rptr + AW'(1);
        {bus.x_in, bus.y_in, bus.width, bus.height, bus.c_in} <= mem[rptr];
      end
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
endmodule
